// File: rtl/miriscv_int_controller.sv
// Core-side interrupt responder: round-robin scan of masked request lines,
// single in-flight interrupt tracked through acknowledge and mret.
module miriscv_int_controller #(
  parameter int N_INT = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_INT-1:0] int_req_i,
  input  logic [N_INT-1:0] mie_i,
  input  logic             int_ack_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_INT-1:0] int_fin_o
);

  localparam int IW = $clog2(N_INT);

  typedef enum logic [1:0] {
    SCAN,
    PENDING,
    SERVICE
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             int_q, int_d;
  logic [31:0]      mcause_q, mcause_d;
  logic [N_INT-1:0] fin_q, fin_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= SCAN;
      cnt_q    <= '0;
      idx_q    <= '0;
      int_q    <= 1'b0;
      mcause_q <= '0;
      fin_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      int_q    <= int_d;
      mcause_q <= mcause_d;
      fin_q    <= fin_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    int_d    = int_q;
    mcause_d = mcause_q;
    fin_d    = '0;

    case (state_q)
      SCAN: begin
        int_d    = 1'b0;
        mcause_d = '0;
        if (int_req_i[cnt_q] & mie_i[cnt_q]) begin
          idx_d    = cnt_q;
          state_d  = PENDING;
          int_d    = 1'b1;
          mcause_d = {1'b1, {(31-IW){1'b0}}, cnt_q};
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end

      // Ack wins over a simultaneous withdrawal; mret is meaningless here.
      PENDING: begin
        if (int_ack_i) begin
          state_d = SERVICE;
          int_d   = 1'b0;
        end else if (!(int_req_i[idx_q] & mie_i[idx_q])) begin
          state_d  = SCAN;
          int_d    = 1'b0;
          mcause_d = '0;
          cnt_d    = idx_q + IW'(1);
        end
      end

      // Restarting the sweep after the serviced line makes it examined last.
      SERVICE: begin
        if (int_rst_i) begin
          state_d  = SCAN;
          mcause_d = '0;
          fin_d    = N_INT'(1) << idx_q;
          cnt_d    = idx_q + IW'(1);
        end
      end

      default: begin
        state_d  = SCAN;
        int_d    = 1'b0;
        mcause_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  assign int_o     = int_q;
  assign mcause_o  = mcause_q;
  assign int_fin_o = fin_q;

endmodule

// File: tb/tb_miriscv_int_controller.sv
// Self-checking bench for miriscv_int_controller: directed scenarios plus a
// randomized run against an integer-arithmetic model of the scan/service rules.
module tb_miriscv_int_controller;

  localparam int N = 32;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [N-1:0]  int_req_i = '0;
  logic [N-1:0]  mie_i = '0;
  logic          int_ack_i = 1'b0;
  logic          int_rst_i = 1'b0;
  logic          int_o;
  logic [31:0]   mcause_o;
  logic [N-1:0]  int_fin_o;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: mode 0 = waiting, 1 = offered to core, 2 = handler running
  int m_mode, m_ptr, m_line, m_fin;

  miriscv_int_controller #(.N_INT(N)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .int_req_i (int_req_i),
    .mie_i     (mie_i),
    .int_ack_i (int_ack_i),
    .int_rst_i (int_rst_i),
    .int_o     (int_o),
    .mcause_o  (mcause_o),
    .int_fin_o (int_fin_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic exp_int();
    return (m_mode == 1);
  endfunction

  function automatic logic [31:0] exp_mcause();
    return (m_mode != 0) ? (32'h8000_0000 | 32'(m_line)) : 32'h0;
  endfunction

  function automatic logic [N-1:0] exp_fin();
    logic [N-1:0] v;
    v = '0;
    if (m_fin >= 0) v[m_fin] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_line = 0; m_fin = -1;
  endtask

  // Advance one clock: evaluate the model on the inputs present before the
  // edge, then settle 1ns past the edge so tasks can sample and re-drive.
  task automatic tick();
    int nm, np, nl, nf;
    nm = m_mode; np = m_ptr; nl = m_line; nf = -1;
    case (m_mode)
      0: if (int_req_i[m_ptr] && mie_i[m_ptr]) begin nl = m_ptr; nm = 1; end
         else np = (m_ptr + 1) % N;
      1: if (int_ack_i) nm = 2;
         else if (!(int_req_i[m_line] && mie_i[m_line])) begin
           nm = 0; np = (m_line + 1) % N;
         end
      default: if (int_rst_i) begin nf = m_line; nm = 0; np = (m_line + 1) % N; end
    endcase
    @(posedge clk_i);
    #1;
    m_mode = nm; m_ptr = np; m_line = nl; m_fin = nf;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    int_ack_i = 1'b0;
    int_rst_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    model_reset();
  endtask

  task automatic pulse_ack();
    int_ack_i = 1'b1; tick(); int_ack_i = 1'b0;
  endtask

  task automatic pulse_rst();
    int_rst_i = 1'b1; tick(); int_rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    #12;
    n_cmp++; if (int_o !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_int: got %b expected 0", int_o); end
    n_cmp++; if (mcause_o !== 32'h0) begin n_mis++; $display("[TB] FAIL reset_mcause: got %h expected 0", mcause_o); end
    n_cmp++; if (int_fin_o !== '0) begin n_mis++; $display("[TB] FAIL reset_fin: got %h expected 0", int_fin_o); end
  endtask

  task automatic test_basic();
    mie_i = '1;
    int_req_i = 32'h0000_0020;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (int_o !== 1'b0) begin n_mis++; $display("[TB] FAIL basic_early: got %b expected 0 after edge 5", int_o); end
    tick();
    n_cmp++; if (int_o !== 1'b1) begin n_mis++; $display("[TB] FAIL basic_rise: got %b expected 1 on edge 6", int_o); end
    n_cmp++; if (mcause_o !== 32'h8000_0005) begin n_mis++; $display("[TB] FAIL basic_mcause: got %h expected 80000005", mcause_o); end
    tick(); tick();
    pulse_ack();
    n_cmp++; if (int_o !== 1'b0) begin n_mis++; $display("[TB] FAIL basic_ack_int: got %b expected 0", int_o); end
    n_cmp++; if (mcause_o !== 32'h8000_0005) begin n_mis++; $display("[TB] FAIL basic_ack_mcause: got %h expected 80000005", mcause_o); end
    tick(); tick();
    n_cmp++; if (int_fin_o !== '0) begin n_mis++; $display("[TB] FAIL basic_service_fin: got %h expected 0", int_fin_o); end
    pulse_rst();
    n_cmp++; if (int_fin_o !== 32'h0000_0020) begin n_mis++; $display("[TB] FAIL basic_fin: got %h expected 00000020", int_fin_o); end
    n_cmp++; if (mcause_o !== 32'h0) begin n_mis++; $display("[TB] FAIL basic_fin_mcause: got %h expected 0", mcause_o); end
    int_req_i = '0;
    tick();
    n_cmp++; if (int_fin_o !== '0) begin n_mis++; $display("[TB] FAIL basic_fin_width: got %h expected 0", int_fin_o); end
  endtask

  task automatic test_masking();
    int bad;
    int_req_i = 32'h0000_0020;
    mie_i = '0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (int_o !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_mis++; $display("[TB] FAIL mask_hold: int_o high in %0d cycles expected 0", bad); end
    mie_i = 32'h0000_0020;
    for (int i = 0; i < 32 && int_o !== 1'b1; i++) tick();
    n_cmp++; if (int_o !== 1'b1) begin n_mis++; $display("[TB] FAIL mask_enable: got %b expected 1 within 32 cycles", int_o); end
    n_cmp++; if (mcause_o !== exp_mcause()) begin n_mis++; $display("[TB] FAIL mask_mcause: got %h expected %h", mcause_o, exp_mcause()); end
    pulse_ack(); pulse_rst();
    int_req_i = '0;
    mie_i = '1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [31:0] order [3];
    order[0] = 32'h8000_0003; order[1] = 32'h8000_0007; order[2] = 32'h8000_0003;
    mie_i = '1;
    int_req_i = '0;
    do_reset();
    int_req_i = 32'h0000_0088;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2 * N && int_o !== 1'b1; i++) tick();
      n_cmp++; if (mcause_o !== order[k] || int_o !== 1'b1) begin
        n_mis++; $display("[TB] FAIL rr_order%0d: got int=%b mcause=%h expected int=1 mcause=%h", k, int_o, mcause_o, order[k]);
      end
      pulse_ack(); pulse_rst();
    end
    int_req_i = '0;
    tick();
  endtask

  task automatic test_withdrawal();
    int fins;
    mie_i = '1;
    int_req_i = '0;
    do_reset();
    int_req_i = 32'h0000_0200;
    fins = 0;
    for (int i = 0; i < 2 * N && int_o !== 1'b1; i++) tick();
    n_cmp++; if (mcause_o !== 32'h8000_0009) begin n_mis++; $display("[TB] FAIL wd_offer: got %h expected 80000009", mcause_o); end
    int_req_i = '0;
    tick();
    if (int_fin_o !== '0) fins++;
    n_cmp++; if (int_o !== 1'b0) begin n_mis++; $display("[TB] FAIL wd_fall: got %b expected 0", int_o); end
    n_cmp++; if (mcause_o !== 32'h0) begin n_mis++; $display("[TB] FAIL wd_mcause: got %h expected 0", mcause_o); end
    int_req_i = 32'h0000_0601;
    tick();
    if (int_fin_o !== '0) fins++;
    n_cmp++; if (int_o !== 1'b1 || mcause_o !== 32'h8000_000A) begin
      n_mis++; $display("[TB] FAIL wd_resume: got int=%b mcause=%h expected int=1 mcause=8000000a", int_o, mcause_o);
    end
    n_cmp++; if (fins != 0) begin n_mis++; $display("[TB] FAIL wd_nofin: got %0d fin cycles expected 0", fins); end
    pulse_ack(); pulse_rst();
    int_req_i = '0;
    tick();
  endtask

  task automatic test_handshakes();
    int bad;
    mie_i = '1;
    int_req_i = '0;
    do_reset();
    int_req_i = 32'h0000_0004;
    for (int i = 0; i < 2 * N && int_o !== 1'b1; i++) tick();
    int_ack_i = 1'b1; int_rst_i = 1'b1;
    tick();
    int_ack_i = 1'b0; int_rst_i = 1'b0;
    n_cmp++; if (int_o !== 1'b0 || mcause_o !== 32'h8000_0002) begin
      n_mis++; $display("[TB] FAIL hs_both: got int=%b mcause=%h expected int=0 mcause=80000002", int_o, mcause_o);
    end
    tick();
    n_cmp++; if (int_fin_o !== '0) begin n_mis++; $display("[TB] FAIL hs_both_fin: got %h expected 0", int_fin_o); end
    pulse_rst();
    n_cmp++; if (int_fin_o !== 32'h0000_0004) begin n_mis++; $display("[TB] FAIL hs_fin: got %h expected 00000004", int_fin_o); end
    int_req_i = '0;
    bad = 0;
    int_rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (int_fin_o !== '0 || int_o !== 1'b0 || mcause_o !== 32'h0) bad++;
    end
    int_rst_i = 1'b0;
    n_cmp++; if (bad != 0) begin n_mis++; $display("[TB] FAIL hs_scan_rst: got %0d disturbed cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid_service();
    int fins;
    mie_i = '1;
    int_req_i = '0;
    do_reset();
    int_req_i = 32'h0000_0010;
    for (int i = 0; i < 2 * N && int_o !== 1'b1; i++) tick();
    pulse_ack();
    int_req_i = '0;
    tick();
    n_cmp++; if (mcause_o !== 32'h8000_0004) begin n_mis++; $display("[TB] FAIL rms_service: got %h expected 80000004", mcause_o); end
    #2;
    rst_n_i = 1'b0;
    #1;
    n_cmp++; if (int_o !== 1'b0 || mcause_o !== 32'h0 || int_fin_o !== '0) begin
      n_mis++; $display("[TB] FAIL rms_async: got int=%b mcause=%h fin=%h expected all 0", int_o, mcause_o, int_fin_o);
    end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    model_reset();
    fins = 0;
    int_rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      int_rst_i = 1'b0;
      if (int_fin_o !== '0) fins++;
    end
    n_cmp++; if (fins != 0) begin n_mis++; $display("[TB] FAIL rms_nofin: got %0d fin cycles expected 0", fins); end
  endtask

  task automatic test_random();
    mie_i = '1;
    int_req_i = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) int_req_i = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 15) == 0) mie_i = $urandom | $urandom;
      if (m_fin >= 0 && $urandom_range(0, 1) == 0) int_req_i[m_fin] = 1'b0;
      int_ack_i = ($urandom_range(0, 2) == 0);
      int_rst_i = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp++; if (int_o !== exp_int()) begin n_mis++; $display("[TB] FAIL rnd_int c=%0d: got %b expected %b", c, int_o, exp_int()); end
      n_cmp++; if (mcause_o !== exp_mcause()) begin n_mis++; $display("[TB] FAIL rnd_mcause c=%0d: got %h expected %h", c, mcause_o, exp_mcause()); end
      n_cmp++; if (int_fin_o !== exp_fin()) begin n_mis++; $display("[TB] FAIL rnd_fin c=%0d: got %h expected %h", c, int_fin_o, exp_fin()); end
    end
    int_ack_i = 1'b0;
    int_rst_i = 1'b0;
  endtask

  initial begin
    model_reset();
    $display("[TB] starting miriscv_int_controller bench");
    test_reset();
    test_basic();
    test_masking();
    test_round_robin();
    test_withdrawal();
    test_handshakes();
    test_reset_mid_service();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
